alu_seq_top: RTL and testbench

Parametrised, multi-cycle successor to the button-driven ALU top level. Operands A and B and the opcode are loaded from the switch bank through edge-detected push-buttons. Execution runs in a small state machine: single-cycle for logic/arithmetic, bit-serial for shifts. The result is presented on the LEDs with busy/valid status and optional flags. It is the board-facing top of the ALU lab design.

---
 rtl/alu_seq_top.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_alu_seq_top.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_top.sv
//-----------------------------------------------------------------------------
// alu_seq_top
//
// Board-facing top of the ALU lab design. Operands A and B and the opcode
// are loaded from the switch bank through edge-detected push-buttons.
// Execution is sequenced by a small state machine:
//   - logic/arithmetic ops finish in one cycle;
//   - shifts run bit-serially, one bit per cycle.
// The result is registered onto the LEDs together with busy/valid status.
//
// Optional feature macro: ALU_FLAGS_EN
//   defined   -> o_flags = {N, Z, C, V} registered alongside o_led
//   undefined -> o_flags tied to 4'b0000, no flag logic built
//
// Ports
//   clock    : system clock, all state on rising edge
//   i_reset  : asynchronous, active-low reset
//   i_sw     : switch bank (operand data, opcode in low NB_OP bits)
//   i_btn    : raw push-buttons, already synchronous to clock
//              bit0 load A, bit1 load B, bit2 load opcode + execute
//   o_led    : registered result
//   o_busy   : execution in progress, presses are ignored
//   o_valid  : one-cycle pulse when o_led / o_err were updated
//   o_err    : last executed opcode unsupported (held until next execute)
//   o_flags  : {N, Z, C, V}
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_seq_top #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int NB_BTN  = 3,
    parameter int NB_CNT  = $clog2(NB_DATA) + 1
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic [NB_BTN-1:0]  i_btn,
    output logic [NB_DATA-1:0] o_led,
    output logic               o_busy,
    output logic               o_valid,
    output logic               o_err,
    output logic [3:0]         o_flags
);

    localparam int MSB = NB_DATA - 1;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    // Opcode map
    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

    localparam logic [NB_CNT-1:0]  CNT_ZERO  = {NB_CNT{1'b0}};
    localparam logic [NB_CNT-1:0]  CNT_ONE   = NB_CNT'(1'b1);
    localparam logic [NB_CNT-1:0]  CNT_MAX   = NB_CNT'(NB_DATA);
    localparam logic [NB_DATA-1:0] DATA_ZERO = {NB_DATA{1'b0}};
    localparam logic [NB_DATA-1:0] DATA_MAX  = NB_DATA'(NB_DATA);

    //-------------------------------------------------------------------------
    // Helper functions
    //-------------------------------------------------------------------------
    function automatic logic is_shift_op(input logic [NB_OP-1:0] op);
        return (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_valid_op(input logic [NB_OP-1:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Shift distance saturates at the data width: larger B gives the same
    // all-fill result as a full-width shift.
    function automatic logic [NB_CNT-1:0] shift_amount(input logic [NB_DATA-1:0] b);
        logic [NB_CNT-1:0] k;
        if (b > DATA_MAX) begin
            k = CNT_MAX;
        end else begin
            k = NB_CNT'(b);
        end
        return k;
    endfunction

    //-------------------------------------------------------------------------
    // Declarations
    //-------------------------------------------------------------------------
    logic [1:0]         state_r,  state_nxt_s;
    logic [NB_DATA-1:0] a_r,      a_nxt_s;
    logic [NB_DATA-1:0] b_r,      b_nxt_s;
    logic [NB_OP-1:0]   op_r,     op_nxt_s;
    logic [NB_DATA-1:0] work_r,   work_nxt_s;
    logic [NB_CNT-1:0]  cnt_r,    cnt_nxt_s;
    logic [NB_BTN-1:0]  btn_q_r;
    logic [NB_BTN-1:0]  press_s;
    logic [NB_DATA-1:0] led_r,    led_nxt_s;
    logic               err_r,    err_nxt_s;
    logic               valid_r,  valid_nxt_s;
    logic               busy_r;
    logic               shift_fill_s;
    logic [NB_DATA-1:0] alu_res_s;

    // Rising-edge detect: a held button produces a single press. btn_q_r
    // tracks in every state, so a button held through busy never fires late.
    assign press_s = i_btn & ~btn_q_r;

    // SRA replicates the sign bit; work_r[MSB] still holds A's sign at every step.
    assign shift_fill_s = (op_r == OP_SRA) ? work_r[MSB] : 1'b0;

    // Result selection for the EXEC cycle; shifts take the serial work register.
    always_comb begin
        alu_res_s = led_r;
        case (op_r)
            OP_ADD:         alu_res_s = a_r + b_r;
            OP_SUB:         alu_res_s = a_r - b_r;
            OP_AND:         alu_res_s = a_r & b_r;
            OP_OR:          alu_res_s = a_r | b_r;
            OP_XOR:         alu_res_s = a_r ^ b_r;
            OP_NOR:         alu_res_s = ~(a_r | b_r);
            OP_SRL, OP_SRA: alu_res_s = work_r;
            default:        alu_res_s = led_r;
        endcase
    end

    // Next-state and datapath control for the IDLE / SHIFT / EXEC sequencer.
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        op_nxt_s    = op_r;
        work_nxt_s  = work_r;
        cnt_nxt_s   = cnt_r;
        led_nxt_s   = led_r;
        err_nxt_s   = err_r;
        valid_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (press_s[0]) begin
                    a_nxt_s = i_sw;
                end else begin
                    a_nxt_s = a_r;
                end
                if (press_s[1]) begin
                    b_nxt_s = i_sw;
                end else begin
                    b_nxt_s = b_r;
                end
                // Execute sees operands loaded in the same cycle.
                if (press_s[2]) begin
                    op_nxt_s   = i_sw[NB_OP-1:0];
                    work_nxt_s = a_nxt_s;
                    cnt_nxt_s  = shift_amount(b_nxt_s);
                    // A zero-distance shift needs no serial steps.
                    if (is_shift_op(op_nxt_s) && (cnt_nxt_s != CNT_ZERO)) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_EXEC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (cnt_r != CNT_ZERO) begin
                    work_nxt_s = {shift_fill_s, work_r[MSB:1]};
                    cnt_nxt_s  = cnt_r - CNT_ONE;
                    // Leave straight after the last step so the total latency is k+1.
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_EXEC;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end

            ST_EXEC: begin
                valid_nxt_s = 1'b1;
                state_nxt_s = ST_IDLE;
                // Unsupported ops leave the previous result on display.
                if (is_valid_op(op_r)) begin
                    led_nxt_s = alu_res_s;
                    err_nxt_s = 1'b0;
                end else begin
                    led_nxt_s = led_r;
                    err_nxt_s = 1'b1;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer, operand and output registers.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
            a_r     <= {NB_DATA{1'b0}};
            b_r     <= {NB_DATA{1'b0}};
            op_r    <= {NB_OP{1'b0}};
            work_r  <= {NB_DATA{1'b0}};
            cnt_r   <= {NB_CNT{1'b0}};
            btn_q_r <= {NB_BTN{1'b0}};
            led_r   <= {NB_DATA{1'b0}};
            err_r   <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            op_r    <= op_nxt_s;
            work_r  <= work_nxt_s;
            cnt_r   <= cnt_nxt_s;
            btn_q_r <= i_btn;
            led_r   <= led_nxt_s;
            err_r   <= err_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    assign o_led   = led_r;
    assign o_err   = err_r;
    assign o_valid = valid_r;
    assign o_busy  = busy_r;

`ifdef ALU_FLAGS_EN
    //-------------------------------------------------------------------------
    // Status flags {N, Z, C, V}
    //-------------------------------------------------------------------------
    logic               shc_r;
    logic [3:0]         flags_r, flags_nxt_s;
    logic [NB_DATA:0]   add_full_s, sub_full_s;
    logic               flag_c_s, flag_v_s;
    logic               exec_start_s, shift_step_s, commit_s;

    assign exec_start_s = (state_r == ST_IDLE)  && press_s[2];
    assign shift_step_s = (state_r == ST_SHIFT) && (cnt_r != CNT_ZERO);
    assign commit_s     = (state_r == ST_EXEC)  && is_valid_op(op_r);

    // Carry and overflow from extended-width add/sub; SUB carry is no-borrow.
    always_comb begin
        add_full_s = {1'b0, a_r} + {1'b0, b_r};
        sub_full_s = {1'b0, a_r} + {1'b0, ~b_r} + {{NB_DATA{1'b0}}, 1'b1};
        case (op_r)
            OP_ADD: begin
                flag_c_s = add_full_s[NB_DATA];
                flag_v_s = (a_r[MSB] == b_r[MSB]) && (add_full_s[MSB] != a_r[MSB]);
            end
            OP_SUB: begin
                flag_c_s = sub_full_s[NB_DATA];
                flag_v_s = (a_r[MSB] != b_r[MSB]) && (sub_full_s[MSB] != a_r[MSB]);
            end
            OP_SRL, OP_SRA: begin
                flag_c_s = shc_r;
                flag_v_s = 1'b0;
            end
            default: begin
                flag_c_s = 1'b0;
                flag_v_s = 1'b0;
            end
        endcase
        flags_nxt_s = {alu_res_s[MSB], (alu_res_s == DATA_ZERO), flag_c_s, flag_v_s};
    end

    // Last bit shifted out; cleared at execute so k = 0 reports C = 0.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            shc_r <= 1'b0;
        end else if (exec_start_s) begin
            shc_r <= 1'b0;
        end else if (shift_step_s) begin
            shc_r <= work_r[0];
        end else begin
            shc_r <= shc_r;
        end
    end

    // Flags register, updated together with o_led.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            flags_r <= 4'b0000;
        end else if (commit_s) begin
            flags_r <= flags_nxt_s;
        end else begin
            flags_r <= flags_r;
        end
    end

    assign o_flags = flags_r;
`else
    assign o_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_seq_top.sv
`timescale 1ns/1ps

module tb_alu_seq_top;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [7:0] i_sw;
    logic [2:0] i_btn;
    logic [7:0] o_led;
    logic       o_busy;
    logic       o_valid;
    logic       o_err;
    logic [3:0] o_flags;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the bench believes is loaded / displayed.
    int m_a, m_b, m_led, m_flags, m_err;

    alu_seq_top #(
        .NB_DATA(8),
        .NB_OP  (6),
        .NB_BTN (3)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .i_sw   (i_sw),
        .i_btn  (i_btn),
        .o_led  (o_led),
        .o_busy (o_busy),
        .o_valid(o_valid),
        .o_err  (o_err),
        .o_flags(o_flags)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural ALU: plain integer arithmetic on 8-bit values.
    task automatic model(input int a, input int b, input logic [5:0] op,
                         output int led, output int flags, output int err, output int lat);
        int k, r, c, v, sa, sb, sum;
        logic sup;
        k   = (b > 8) ? 8 : b;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        sup = 1'b1; c = 0; v = 0; r = 0; lat = 1;
        case (op)
            6'b100000: begin
                sum = a + b; r = sum & 255; c = (sum >> 8) & 1;
                v = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
            end
            6'b100010: begin
                r = (a - b) & 255; c = (a >= b) ? 1 : 0;
                v = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
            end
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = (~(a | b)) & 255;
            6'b000010: begin
                r = (k >= 8) ? 0 : (a >> k);
                c = (k == 0) ? 0 : ((a >> (k - 1)) & 1);
                lat = k + 1;
            end
            6'b000011: begin
                r = (sa >>> k) & 255;
                c = (k == 0) ? 0 : ((sa >>> (k - 1)) & 1);
                lat = k + 1;
            end
            default: sup = 1'b0;
        endcase
        if (sup) begin
            led = r;
            err = 0;
`ifdef ALU_FLAGS_EN
            flags = ((r >> 7) & 1) * 8 + ((r == 0) ? 4 : 0) + c * 2 + v;
`else
            flags = 0;
`endif
        end else begin
            led   = m_led;
            flags = m_flags;
            err   = 1;
        end
    endtask

    task automatic load(input logic [2:0] mask, input logic [7:0] v);
        i_sw  = v;
        i_btn = mask;
        @(negedge clock);
        i_btn = 3'b000;
        if (mask[0]) m_a = v;
        if (mask[1]) m_b = v;
    endtask

    // Press execute (optionally with loads), then check latency, busy and result.
    task automatic exec_press(input logic [7:0] sw, input logic [2:0] mask, input string tag);
        int e_led, e_flags, e_err, lat, cyc, busy_cnt;
        if (mask[0]) m_a = sw;
        if (mask[1]) m_b = sw;
        model(m_a, m_b, sw[5:0], e_led, e_flags, e_err, lat);
        i_sw  = sw;
        i_btn = mask;
        @(negedge clock);
        i_btn = 3'b000;
        chk({tag, "_busy_start"}, {31'd0, o_busy}, 32'd1);
        busy_cnt = (o_busy === 1'b1) ? 1 : 0;
        cyc = 0;
        while (o_valid !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (o_busy === 1'b1) busy_cnt++;
        end
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_busy_cycles"}, busy_cnt, lat);
        chk({tag, "_led"}, {24'd0, o_led}, e_led);
        chk({tag, "_flags"}, {28'd0, o_flags}, e_flags);
        chk({tag, "_err"}, {31'd0, o_err}, e_err);
        chk({tag, "_busy_end"}, {31'd0, o_busy}, 32'd0);
        @(negedge clock);
        chk({tag, "_valid_pulse"}, {31'd0, o_valid}, 32'd0);
        m_led = e_led; m_flags = e_flags; m_err = e_err;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [9];
        int e_led, e_flags, e_err, lat, cyc, seen_valid;
        logic [7:0] ra, rb;

        ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                6'b100111, 6'b000010, 6'b000011, 6'b111111};

        i_reset = 1'b0; i_sw = 8'h00; i_btn = 3'b000;
        m_a = 0; m_b = 0; m_led = 0; m_flags = 0; m_err = 0;
        repeat (2) @(negedge clock);
        chk("rst_led",   {24'd0, o_led},   32'd0);
        chk("rst_busy",  {31'd0, o_busy},  32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_err",   {31'd0, o_err},   32'd0);
        chk("rst_flags", {28'd0, o_flags}, 32'd0);
        i_reset = 1'b1;
        @(negedge clock);

        // Directed cases
        load(3'b001, 8'h7F); load(3'b010, 8'h01);
        exec_press(8'h20, 3'b100, "add_ovf");
        load(3'b001, 8'h05); load(3'b010, 8'h05);
        exec_press(8'h22, 3'b100, "sub_zero");
        exec_press(8'h27, 3'b100, "nor");
        load(3'b001, 8'h90); load(3'b010, 8'h03);
        exec_press(8'h03, 3'b100, "sra3");
        exec_press(8'h02, 3'b100, "srl3");
        load(3'b010, 8'h20);
        exec_press(8'h02, 3'b100, "srl_max");
        exec_press(8'h03, 3'b100, "sra_max");
        exec_press(8'h3F, 3'b100, "bad_op");
        load(3'b010, 8'h00);
        exec_press(8'h02, 3'b100, "srl_k0");
        exec_press(8'h20, 3'b111, "all_btn");

        // Held load-A: only the first cycle's value may be captured.
        i_sw = 8'h33; i_btn = 3'b001;
        @(negedge clock);
        i_sw = 8'h44;
        repeat (9) @(negedge clock);
        i_btn = 3'b000;
        @(negedge clock);
        m_a = 32'h33;
        load(3'b010, 8'h00);
        exec_press(8'h20, 3'b100, "held_a");

        // Load-B pressed and held during a shift must never take effect.
        load(3'b001, 8'h90); load(3'b010, 8'h03);
        model(m_a, m_b, 6'b000010, e_led, e_flags, e_err, lat);
        i_sw = 8'h02; i_btn = 3'b100;
        @(negedge clock);
        i_btn = 3'b000;
        @(negedge clock);
        i_sw = 8'h01; i_btn = 3'b010;
        cyc = 1;
        while (o_valid !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        chk("busy_b_latency", cyc, lat);
        chk("busy_b_led", {24'd0, o_led}, e_led);
        m_led = e_led; m_flags = e_flags; m_err = e_err;
        repeat (3) @(negedge clock);
        exec_press(8'h20, 3'b100, "busy_b_ignored");

        // Reset in the middle of a shift aborts with no valid pulse.
        load(3'b001, 8'h81); load(3'b010, 8'h08);
        i_sw = 8'h03; i_btn = 3'b100;
        @(negedge clock);
        i_btn = 3'b000;
        repeat (3) @(negedge clock);
        i_reset = 1'b0;
        #1;
        chk("midrst_led",   {24'd0, o_led},   32'd0);
        chk("midrst_busy",  {31'd0, o_busy},  32'd0);
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_err",   {31'd0, o_err},   32'd0);
        chk("midrst_flags", {28'd0, o_flags}, 32'd0);
        seen_valid = 0;
        repeat (3) begin
            @(negedge clock);
            if (o_valid !== 1'b0) seen_valid++;
        end
        i_reset = 1'b1;
        repeat (12) begin
            @(negedge clock);
            if (o_valid !== 1'b0) seen_valid++;
        end
        chk("midrst_no_valid", seen_valid, 32'd0);
        m_a = 0; m_b = 0; m_led = 0; m_flags = 0; m_err = 0;
        exec_press(8'h25, 3'b100, "post_rst_or");

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                rb = 8'($urandom_range(0, 10));
            end else begin
                rb = 8'($urandom_range(0, 255));
            end
            load(3'b001, ra);
            load(3'b010, rb);
            exec_press({2'b00, ops[$urandom_range(0, 8)]}, 3'b100, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
